sprite_rom_arbiter: RTL and testbench

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/sprite_rom_arbiter.sv | 88 ++++++++
 tb/tb_sprite_rom_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared defaults for the sprite ROM path: address/pixel widths and the transparency key.
package sprite_pkg;

  localparam int unsigned ADDRESS_DEFAULT    = 11;
  localparam int unsigned COLOR_BITS_DEFAULT = 24;
  localparam logic [23:0] TRANSPARENT_KEY_DEFAULT = 24'hFF00FF;

  // Index width that stays legal (>= 1 bit) even for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts just after the previous winner.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last_winner,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_winner) + 32'd1 + i) % NUM_REQ);
      if (!gnt_valid && eligible[cand]) begin
        gnt_valid = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one async-read sprite ROM between NUM_REQ renderers: grant stage drives
// the ROM address, response stage registers the pixel and its transparency flag.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned ADDRESS    = ADDRESS_DEFAULT,
  parameter int unsigned COLOR_BITS = COLOR_BITS_DEFAULT,
  parameter int unsigned NUM_REQ    = 2,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT_KEY = COLOR_BITS'(TRANSPARENT_KEY_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][ADDRESS-1:0] req_addr,
  output logic [ADDRESS-1:0]              rom_addr,
  input  logic [COLOR_BITS-1:0]           rom_dout,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [COLOR_BITS-1:0]           rdata,
  output logic                            rtransparent
);

  localparam int unsigned      IDX_W      = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] outstanding_q, outstanding_d;
  logic [IDX_W-1:0]   last_winner_q;
  logic               s0_valid_q;
  logic [IDX_W-1:0]   s0_id_q;

  logic [NUM_REQ-1:0] eligible;
  logic               gnt_valid;
  logic [IDX_W-1:0]   winner;

  assign eligible = req & ~outstanding_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .last_winner (last_winner_q),
    .gnt_valid   (gnt_valid),
    .winner      (winner)
  );

  // A granted requester is never eligible, so set and clear never hit the same bit.
  always_comb begin
    outstanding_d = outstanding_q;
    if (s0_valid_q) outstanding_d[s0_id_q] = 1'b0;
    if (gnt_valid)  outstanding_d[winner]  = 1'b1;
  end

  // Stage 0: grant register and ROM address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr      <= '0;
      last_winner_q <= LAST_RESET;
      s0_valid_q    <= 1'b0;
      s0_id_q       <= '0;
      outstanding_q <= '0;
    end else begin
      if (gnt_valid) begin
        rom_addr      <= req_addr[winner];
        last_winner_q <= winner;
      end
      s0_valid_q    <= gnt_valid;
      s0_id_q       <= winner;
      outstanding_q <= outstanding_d;
    end
  end

  // Stage 1: response register; data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid       <= '0;
      rdata        <= '0;
      rtransparent <= 1'b0;
    end else begin
      if (s0_valid_q) begin
        rdata        <= rom_dout;
        rtransparent <= (rom_dout == TRANSPARENT_KEY);
        rvalid       <= NUM_REQ'(1) << s0_id_q;
      end else begin
        rvalid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed sequences, a single-read vector table and
// a randomized run against a transaction-level reference model.
module tb_sprite_rom_arbiter;

  localparam int unsigned AW  = 11;
  localparam int unsigned CW  = 24;
  localparam int unsigned NR  = 2;
  localparam logic [CW-1:0] KEY = 24'hFF00FF;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NR-1:0]            req;
  logic [NR-1:0][AW-1:0]    req_addr;
  logic [AW-1:0]            rom_addr;
  logic [CW-1:0]            rom_dout;
  logic [NR-1:0]            rvalid;
  logic [CW-1:0]            rdata;
  logic                     rtransparent;

  logic [CW-1:0] mem [0:(1<<AW)-1];

  assign rom_dout = mem[rom_addr];

  always #5 clk = ~clk;

  sprite_rom_arbiter #(
    .ADDRESS         (AW),
    .COLOR_BITS      (CW),
    .NUM_REQ         (NR),
    .TRANSPARENT_KEY (KEY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_addr     (req_addr),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .rtransparent (rtransparent)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req      = '0;
    req_addr = '0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic          exp_tr;
  } vec_t;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    int            due;
  } txn_t;

  vec_t vecs [6];

  // Reference model state
  txn_t          q[$];
  txn_t          t;
  logic [NR-1:0] pend;
  int            last;
  logic [AW-1:0] exp_addr;
  logic [NR-1:0] exp_rvalid;
  logic [CW-1:0] exp_rdata;
  logic          exp_tr;
  logic [NR-1:0] elig;
  int            best, bestd, d, lat;
  logic          waiting [NR];
  int            others  [NR];

  initial begin
    vecs[0] = '{0, 11'h020, 1'b1};
    vecs[1] = '{0, 11'h021, 1'b0};
    vecs[2] = '{1, 11'h7FF, 1'b0};
    vecs[3] = '{1, 11'h000, 1'b0};
    vecs[4] = '{0, 11'h3A5, 1'b0};
    vecs[5] = '{1, 11'h020, 1'b1};

    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = CW'($urandom);
      if (mem[i] == KEY) mem[i] = mem[i] ^ 24'h000001;
    end
    mem[11'h020] = KEY;
    mem[11'h021] = KEY ^ 24'h000001;

    req      = '0;
    req_addr = '0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_rom_addr", rom_addr, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_rdata", rdata, 0);
    check("reset_rtransparent", rtransparent, 0);
    step();
    step();
    rst_n = 1'b1;

    // Single read from requester 0
    req = 2'b01;
    req_addr[0] = 11'h005;
    step();
    check("first_rom_addr", rom_addr, 11'h005);
    check("first_no_early_rvalid", rvalid, 0);
    step();
    check("first_rvalid", rvalid, 2'b01);
    check("first_rdata", rdata, mem[11'h005]);
    req = '0;
    step();
    check("idle_rvalid", rvalid, 0);
    check("idle_rom_addr_hold", rom_addr, 11'h005);
    check("idle_rdata_hold", rdata, mem[11'h005]);

    // Vector table: one read each, 2-edge latency
    for (int v = 0; v < 6; v++) begin
      req = '0;
      req[vecs[v].id] = 1'b1;
      req_addr[vecs[v].id] = vecs[v].addr;
      lat = 0;
      do begin
        step();
        lat++;
      end while (rvalid == '0 && lat < 8);
      req = '0;
      check("tbl_latency", lat, 2);
      check("tbl_rvalid", rvalid, NR'(1) << vecs[v].id);
      check("tbl_rdata", rdata, mem[vecs[v].addr]);
      check("tbl_rtransparent", rtransparent, vecs[v].exp_tr);
      check("tbl_rom_addr", rom_addr, vecs[v].addr);
    end
    step();

    // Both requesters held: strict alternation
    do_reset();
    req = 2'b11;
    req_addr[0] = 11'h010;
    req_addr[1] = 11'h7FF;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("alt_rom_addr", rom_addr, (k % 2 == 1) ? 11'h010 : 11'h7FF);
      if (k == 1) begin
        check("alt_rvalid_first", rvalid, 0);
      end else begin
        check("alt_rvalid", rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
        check("alt_rdata", rdata, (k % 2 == 0) ? mem[11'h010] : mem[11'h7FF]);
      end
    end
    req = '0;
    step();
    step();

    // Single requester held: one access every two cycles
    do_reset();
    req = 2'b01;
    req_addr[0] = 11'h044;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("solo_rvalid", rvalid, (k % 2 == 0) ? 2'b01 : 2'b00);
    end
    req = '0;
    step();
    step();

    // Reset between grant and response discards the access
    do_reset();
    req = 2'b01;
    req_addr[0] = 11'h030;
    step();
    check("midrst_grant_addr", rom_addr, 11'h030);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_rvalid", rvalid, 0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_no_rvalid_1", rvalid, 0);
    step();
    check("midrst_no_rvalid_2", rvalid, 0);
    req = 2'b11;
    req_addr[0] = 11'h111;
    req_addr[1] = 11'h222;
    step();
    check("midrst_next_grant_0", rom_addr, 11'h111);
    step();
    check("midrst_next_rvalid", rvalid, 2'b01);
    req = '0;
    step();
    step();

    // Randomized run against the transaction model
    do_reset();
    q.delete();
    pend      = '0;
    last      = NR - 1;
    exp_addr  = '0;
    exp_rdata = '0;
    exp_tr    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      waiting[i] = 1'b0;
      others[i]  = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!waiting[i] && $urandom_range(0, 2) != 0) begin
          waiting[i]  = 1'b1;
          others[i]   = 0;
          req_addr[i] = ($urandom_range(0, 7) == 0) ? 11'h020 : AW'($urandom);
        end
        req[i] = waiting[i];
      end

      elig       = req & ~pend;
      exp_rvalid = '0;
      while (q.size() > 0 && q[0].due == cyc) begin
        t = q.pop_front();
        exp_rvalid[t.id] = 1'b1;
        exp_rdata = mem[t.addr];
        exp_tr    = (mem[t.addr] == KEY);
        pend[t.id] = 1'b0;
      end
      best  = -1;
      bestd = NR;
      for (int i = 0; i < NR; i++) begin
        d = (i - last - 1 + NR) % NR;
        if (elig[i] && d < bestd) begin
          best  = i;
          bestd = d;
        end
      end
      if (best >= 0) begin
        exp_addr   = req_addr[best];
        pend[best] = 1'b1;
        last       = best;
        q.push_back('{best, req_addr[best], cyc + 1});
      end

      step();
      check("rand_rom_addr", rom_addr, exp_addr);
      check("rand_rvalid", rvalid, exp_rvalid);
      check("rand_rdata", rdata, exp_rdata);
      check("rand_rtransparent", rtransparent, exp_tr);
      check("rand_rvalid_onehot", 64'($countones(rvalid) <= 1), 64'(1));

      for (int i = 0; i < NR; i++) begin
        if (rvalid[i]) begin
          check("rand_no_starvation", 64'(others[i] <= NR), 64'(1));
          waiting[i] = 1'b0;
          others[i]  = 0;
        end else if (waiting[i] && rvalid != '0) begin
          others[i]++;
        end
      end
    end
    req = '0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
